// File: rtl/vslide_issue.sv
// Slide-pipeline request sequencer: fetches a source register group from the VRF,
// buffers it, then streams it as consecutive beats with slide-unit sideband.
//   state    | meaning
//   S_IDLE   | ready for a command; rejects and vl=0 are resolved here
//   S_FETCH  | issuing VRF reads and capturing in-order responses
//   S_STREAM | emitting buffered beats on consecutive cycles
//   S_FIN    | one-cycle done pulse
module vslide_issue #(
  parameter int REQ_DATA_WIDTH    = 64,
  parameter int REQ_ADDR_WIDTH    = 32,
  parameter int REQ_BYTE_EN_WIDTH = 8,
  // one extra bit so the largest element size (BYTES itself) is representable
  parameter int SHIFT_WIDTH       = $clog2(REQ_DATA_WIDTH/8) + 1,
  parameter bit ENABLE_64_BIT     = 1'b1,
  parameter int MAX_BEATS         = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_opsel,
  input  logic                         cmd_insert,
  input  logic [1:0]                   cmd_sew,
  input  logic [15:0]                  cmd_vl,
  input  logic [REQ_ADDR_WIDTH-1:0]    cmd_vs2_addr,
  input  logic [REQ_ADDR_WIDTH-1:0]    cmd_vd_addr,
  input  logic [REQ_DATA_WIDTH-1:0]    cmd_scalar,
  output logic                         rd_req_valid,
  input  logic                         rd_req_ready,
  output logic [REQ_ADDR_WIDTH-1:0]    rd_req_addr,
  input  logic                         rd_resp_valid,
  input  logic [REQ_DATA_WIDTH-1:0]    rd_resp_data,
  output logic                         out_valid,
  output logic                         out_start,
  output logic                         out_end,
  output logic                         out_opsel,
  output logic                         out_insert,
  output logic [REQ_DATA_WIDTH-1:0]    out_vec0,
  output logic [REQ_DATA_WIDTH-1:0]    out_vec1,
  output logic [SHIFT_WIDTH-1:0]       out_shift,
  output logic [REQ_ADDR_WIDTH-1:0]    out_addr,
  output logic [REQ_BYTE_EN_WIDTH-1:0] out_be,
  output logic [REQ_BYTE_EN_WIDTH-1:0] out_avl_be,
  output logic [11:0]                  out_off,
  output logic                         done,
  output logic                         cmd_err
);
  localparam int BYTES = REQ_DATA_WIDTH / 8;
  localparam int BOFF  = $clog2(BYTES);
  localparam int IDX_W = $clog2(MAX_BEATS);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM, S_FIN} state_t;

  state_t                       r_state;
  logic                         r_cmd_ready, r_done, r_cmd_err;
  logic                         r_opsel, r_insert;
  logic [1:0]                   r_sew;
  logic [CNT_W-1:0]             r_beats, r_req_cnt, r_resp_cnt, r_out_cnt;
  logic [REQ_ADDR_WIDTH-1:0]    r_vs2, r_vd;
  logic [REQ_DATA_WIDTH-1:0]    r_scalar;
  logic [REQ_BYTE_EN_WIDTH-1:0] r_last_be;
  logic [REQ_DATA_WIDTH-1:0]    r_buf [MAX_BEATS];

  logic                         r_out_valid, r_out_start, r_out_end, r_out_opsel, r_out_insert;
  logic [REQ_DATA_WIDTH-1:0]    r_out_vec0, r_out_vec1;
  logic [SHIFT_WIDTH-1:0]       r_out_shift;
  logic [REQ_ADDR_WIDTH-1:0]    r_out_addr;
  logic [REQ_BYTE_EN_WIDTH-1:0] r_out_be, r_out_avl_be;
  logic [11:0]                  r_out_off;

  logic [18:0]                  w_nbytes, w_beats;
  logic [BOFF-1:0]              w_tail;
  logic [REQ_BYTE_EN_WIDTH-1:0] w_ones, w_last_be;
  logic                         w_reject, w_last_rsp, w_ld_en;
  logic [CNT_W-1:0]             w_ld_idx;
  logic [REQ_DATA_WIDTH-1:0]    w_ld_data;

  always_comb begin
    w_nbytes  = {3'b000, cmd_vl} << cmd_sew;
    w_beats   = (w_nbytes + 19'(BYTES - 1)) >> BOFF;
    w_tail    = w_nbytes[BOFF-1:0];
    w_ones    = '1;
    w_last_be = (w_tail == '0) ? w_ones : ~(w_ones << w_tail);
    w_reject  = (w_beats > 19'(MAX_BEATS)) || ((cmd_sew == 2'd3) && !ENABLE_64_BIT);
  end

  // Beat 0 is loaded on the edge that captures the last response, so a
  // single-beat group must forward the response data directly.
  always_comb begin
    w_ld_idx   = (r_state == S_STREAM) ? r_out_cnt : '0;
    w_last_rsp = (r_state == S_FETCH) && rd_resp_valid && (r_resp_cnt == r_beats - 1'b1);
    w_ld_en    = w_last_rsp || ((r_state == S_STREAM) && (r_out_cnt < r_beats));
    w_ld_data  = (w_last_rsp && (r_resp_cnt == '0)) ? rd_resp_data : r_buf[w_ld_idx[IDX_W-1:0]];
  end

  assign rd_req_valid = (r_state == S_FETCH) && (r_req_cnt < r_beats);
  assign rd_req_addr  = r_vs2 + (REQ_ADDR_WIDTH'(r_req_cnt) << BOFF);

  always_ff @(posedge clk) begin
    if ((r_state == S_FETCH) && rd_resp_valid && (r_resp_cnt < r_beats))
      r_buf[r_resp_cnt[IDX_W-1:0]] <= rd_resp_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cmd_ready  <= 1'b0;
      r_done       <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_opsel      <= 1'b0;
      r_insert     <= 1'b0;
      r_sew        <= '0;
      r_beats      <= '0;
      r_req_cnt    <= '0;
      r_resp_cnt   <= '0;
      r_out_cnt    <= '0;
      r_vs2        <= '0;
      r_vd         <= '0;
      r_scalar     <= '0;
      r_last_be    <= '0;
      r_out_valid  <= 1'b0;
      r_out_start  <= 1'b0;
      r_out_end    <= 1'b0;
      r_out_opsel  <= 1'b0;
      r_out_insert <= 1'b0;
      r_out_vec0   <= '0;
      r_out_vec1   <= '0;
      r_out_shift  <= '0;
      r_out_addr   <= '0;
      r_out_be     <= '0;
      r_out_avl_be <= '0;
      r_out_off    <= '0;
    end else begin
      r_done    <= 1'b0;
      r_cmd_err <= 1'b0;
      r_out_valid  <= w_ld_en;
      r_out_start  <= w_ld_en && (w_ld_idx == '0);
      r_out_end    <= w_ld_en && (w_ld_idx == r_beats - 1'b1);
      r_out_opsel  <= w_ld_en && r_opsel;
      r_out_insert <= w_ld_en && r_insert;
      r_out_vec0   <= w_ld_en ? w_ld_data : '0;
      r_out_vec1   <= w_ld_en ? r_scalar : '0;
      r_out_shift  <= w_ld_en ? ({{(SHIFT_WIDTH-1){1'b0}}, 1'b1} << r_sew) : '0;
      r_out_addr   <= w_ld_en ? (r_vd + (REQ_ADDR_WIDTH'(w_ld_idx) << BOFF)) : '0;
      r_out_be     <= !w_ld_en ? '0 : (w_ld_idx == r_beats - 1'b1) ? r_last_be : '1;
      r_out_avl_be <= w_ld_en ? r_last_be : '0;
      r_out_off    <= (w_ld_en && !r_opsel) ? 12'(w_ld_idx) : 12'd0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_opsel    <= cmd_opsel;
            r_insert   <= cmd_insert;
            r_sew      <= cmd_sew;
            r_beats    <= CNT_W'(w_beats);
            r_vs2      <= cmd_vs2_addr;
            r_vd       <= cmd_vd_addr;
            r_scalar   <= cmd_scalar;
            r_last_be  <= w_last_be;
            r_req_cnt  <= '0;
            r_resp_cnt <= '0;
            r_out_cnt  <= '0;
            if (cmd_vl == 16'd0) begin
              r_state     <= S_FIN;
              r_done      <= 1'b1;
              r_cmd_ready <= 1'b0;
            end else if (w_reject) begin
              r_cmd_err <= 1'b1;
            end else begin
              r_state     <= S_FETCH;
              r_cmd_ready <= 1'b0;
            end
          end
        end
        S_FETCH: begin
          if (rd_req_valid && rd_req_ready) r_req_cnt <= r_req_cnt + 1'b1;
          if (rd_resp_valid && (r_resp_cnt < r_beats)) r_resp_cnt <= r_resp_cnt + 1'b1;
          if (w_last_rsp) begin
            r_state   <= S_STREAM;
            r_out_cnt <= CNT_W'(1);
          end
        end
        S_STREAM: begin
          if (r_out_cnt < r_beats) begin
            r_out_cnt <= r_out_cnt + 1'b1;
          end else begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
          end
        end
        S_FIN: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign done       = r_done;
  assign cmd_err    = r_cmd_err;
  assign out_valid  = r_out_valid;
  assign out_start  = r_out_start;
  assign out_end    = r_out_end;
  assign out_opsel  = r_out_opsel;
  assign out_insert = r_out_insert;
  assign out_vec0   = r_out_vec0;
  assign out_vec1   = r_out_vec1;
  assign out_shift  = r_out_shift;
  assign out_addr   = r_out_addr;
  assign out_be     = r_out_be;
  assign out_avl_be = r_out_avl_be;
  assign out_off    = r_out_off;
endmodule
